// File: rtl/coil_bank_model.sv
// coil_bank_model
//   N-channel stepper-coil plant model for closed-loop chopper simulation.
//   Per channel: decodes the four H-bridge gates into drive/decay/shoot-through,
//   integrates a saturating signed coil current, measures the duty of the
//   analog-reference PWM over a shared 2^DW-cycle window to form a target, and
//   returns a registered comparator bit (|current| >= target).
//
// Ports
//   clk             single clock, all state on posedge
//   reset           synchronous, active-high
//   high_1/low_1    bridge side-1 gates, bit i = channel i
//   high_2/low_2    bridge side-2 gates
//   polarity_invert per-channel swap of POS/NEG drive
//   pwm             analog-reference PWM per channel
//   current         signed coil current, channel i at [i*CW +: CW]
//   target          measured duty, channel i at [i*DW +: DW]
//   cmp             1 when |current| >= target
//   shoot_through   sticky shoot-through flag per channel
module coil_bank_model #(
    parameter int NCH  = 2,
    parameter int CW   = 13,
    parameter int DW   = 12,
    parameter int RISE = 4,
    parameter int FALL = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH-1:0]    high_1,
    input  logic [NCH-1:0]    low_1,
    input  logic [NCH-1:0]    high_2,
    input  logic [NCH-1:0]    low_2,
    input  logic [NCH-1:0]    polarity_invert,
    input  logic [NCH-1:0]    pwm,
    output logic [NCH*CW-1:0] current,
    output logic [NCH*DW-1:0] target,
    output logic [NCH-1:0]    cmp,
    output logic [NCH-1:0]    shoot_through
);

    localparam int MW = (CW - 1 > DW) ? CW - 1 : DW;

    // Arithmetic is done one bit wider than the current so the saturation
    // thresholds never overflow.
    localparam logic signed [CW:0] MAX_W  = (CW+1)'(2 ** (CW - 1) - 1);
    localparam logic signed [CW:0] RISE_W = (CW+1)'(RISE);
    localparam logic signed [CW:0] FALL_W = (CW+1)'(FALL);

    logic signed [CW-1:0] cur_q [NCH];
    logic signed [CW-1:0] cur_d [NCH];
    logic [DW-1:0]        tgt_q [NCH];
    logic [DW-1:0]        tgt_d [NCH];
    logic [DW:0]          hc_q  [NCH];
    logic [DW:0]          hc_d  [NCH];
    logic [NCH-1:0]       cmp_q, cmp_d;
    logic [NCH-1:0]       sh_q, sh_d;
    logic [DW-1:0]        win_q, win_d;

    logic                 terminal;
    logic signed [CW:0]   wide;
    logic signed [CW:0]   nxt;
    logic [DW:0]          sum;
    logic [CW-1:0]        mag;
    logic                 pos, neg, shoot;

    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves a value unassigned and no latch is inferred.
        win_d    = win_q + 1'b1;
        terminal = &win_q;
        cmp_d    = cmp_q;
        sh_d     = sh_q;
        wide     = '0;
        nxt      = '0;
        sum      = '0;
        mag      = '0;
        pos      = 1'b0;
        neg      = 1'b0;
        shoot    = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            cur_d[i] = cur_q[i];
            tgt_d[i] = tgt_q[i];
            hc_d[i]  = hc_q[i];

            // Gate decode; shoot-through wins over everything else.
            shoot = (high_1[i] & low_1[i]) | (high_2[i] & low_2[i]);
            pos   = high_1[i] & low_2[i] & ~low_1[i] & ~high_2[i];
            neg   = high_2[i] & low_1[i] & ~high_1[i] & ~low_2[i];
            if (polarity_invert[i]) begin
                {pos, neg} = {neg, pos};
            end

            wide = {cur_q[i][CW-1], cur_q[i]};
            if (shoot) begin
                nxt     = wide;
                sh_d[i] = 1'b1;
            end else if (pos) begin
                nxt = (wide >= MAX_W - RISE_W) ? MAX_W : wide + RISE_W;
            end else if (neg) begin
                // Clamp at -MAX so the most negative code is never produced.
                nxt = (wide <= RISE_W - MAX_W) ? -MAX_W : wide - RISE_W;
            end else if (wide > FALL_W) begin
                nxt = wide - FALL_W;
            end else if (wide < -FALL_W) begin
                nxt = wide + FALL_W;
            end else begin
                // Decay lands on exactly zero and never crosses sign.
                nxt = '0;
            end
            cur_d[i] = nxt[CW-1:0];

            // The terminal sample is counted before the target is loaded; a
            // full-window count (2^DW) saturates to the largest DW-bit value.
            sum = hc_q[i] + {{DW{1'b0}}, pwm[i]};
            if (terminal) begin
                tgt_d[i] = sum[DW] ? '1 : sum[DW-1:0];
                hc_d[i]  = '0;
            end else begin
                hc_d[i]  = sum;
            end

            // Magnitude fits in CW-1 bits because -2^(CW-1) never occurs.
            mag      = cur_q[i][CW-1] ? CW'(-cur_q[i]) : CW'(cur_q[i]);
            cmp_d[i] = MW'(mag[CW-2:0]) >= MW'(tgt_q[i]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_q <= '0;
            cmp_q <= '1;
            sh_q  <= '0;
            for (int i = 0; i < NCH; i++) begin
                cur_q[i] <= '0;
                tgt_q[i] <= '0;
                hc_q[i]  <= '0;
            end
        end else begin
            win_q <= win_d;
            cmp_q <= cmp_d;
            sh_q  <= sh_d;
            for (int i = 0; i < NCH; i++) begin
                cur_q[i] <= cur_d[i];
                tgt_q[i] <= tgt_d[i];
                hc_q[i]  <= hc_d[i];
            end
        end
    end

    always_comb begin
        current = '0;
        target  = '0;
        for (int i = 0; i < NCH; i++) begin
            current[i*CW +: CW] = cur_q[i];
            target[i*DW +: DW]  = tgt_q[i];
        end
    end

    assign cmp           = cmp_q;
    assign shoot_through = sh_q;

endmodule
